// File: rtl/tpu_bridge_pkg.sv
// Shared command, state and payload-length definitions for the pad-side host bridge.
package tpu_bridge_pkg;

    typedef enum logic [2:0] {
        CMD_NOP       = 3'd0,
        CMD_SET_MODE  = 3'd1,
        CMD_SET_BASE  = 3'd2,
        CMD_SET_LEN   = 3'd3,
        CMD_WR_INSTR  = 3'd4,
        CMD_WR_DATA   = 3'd5,
        CMD_RD_STATUS = 3'd6,
        CMD_ILLEGAL   = 3'd7
    } cmd_e;

    typedef enum logic [1:0] {
        RX_HDR,
        RX_PAY,
        RX_ISSUE
    } rx_state_e;

    typedef enum logic {
        TX_IDLE,
        TX_SHIFT
    } tx_state_e;

    localparam int PAY_NOP        = 0;
    localparam int PAY_SET_MODE   = 1;
    localparam int PAY_SET_BASE   = 2;
    localparam int PAY_SET_LEN    = 4;
    localparam int PAY_INSTR_ADDR = 1;
    localparam int PAY_RD_STATUS  = 0;
    localparam int STAT_BYTES     = 1;

    // Payload bytes following a header; instruction/data words scale with DIN_W.
    function automatic int payloadBytes(cmd_e cmd, int dinBytes);
        case (cmd)
            CMD_NOP:       return PAY_NOP;
            CMD_SET_MODE:  return PAY_SET_MODE;
            CMD_SET_BASE:  return PAY_SET_BASE;
            CMD_SET_LEN:   return PAY_SET_LEN;
            CMD_WR_INSTR:  return PAY_INSTR_ADDR + dinBytes;
            CMD_WR_DATA:   return dinBytes;
            CMD_RD_STATUS: return PAY_RD_STATUS;
            default:       return 0;
        endcase
    endfunction

endpackage

// File: rtl/tpu_tx_serializer.sv
// Parallel-load, LSB-first byte serializer with a valid/ready output stream.
module tpu_tx_serializer
    import tpu_bridge_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CNT_W-1:0]  last_i,
    output logic              idle_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [7:0]        out_data_o
);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt_q holds the index of the final byte still to go; the shifter only moves on acceptance.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        case (state_q)
            TX_IDLE: begin
                if (load_i) begin
                    shift_d = data_i;
                    cnt_d   = last_i;
                    state_d = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                if (out_ready_i) begin
                    shift_d = {8'h00, shift_q[DATA_W-1:8]};
                    if (cnt_q == '0) begin
                        state_d = TX_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    assign idle_o      = (state_q == TX_IDLE);
    assign out_valid_o = (state_q == TX_SHIFT);
    assign out_data_o  = shift_q[7:0];

endmodule

// File: rtl/tpu_pad_bridge.sv
// Byte-wide pad bridge: parses pad commands into tpu_core controls and serializes dout/status back out.
module tpu_pad_bridge
    import tpu_bridge_pkg::*;
#(
    parameter int DIN_W   = 64,
    parameter int DOUT_W  = 32,
    parameter int IADDR_W = 8,
    parameter int BASE_W  = 13
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [7:0]         in_data_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [7:0]         out_data_o,
    output logic [2:0]         tpu_mode_o,
    output logic [BASE_W-1:0]  base_addr_o,
    output logic [31:0]        dma_len_o,
    input  logic               busy_i,
    input  logic               done_i,
    output logic               din_valid_o,
    input  logic               din_ready_i,
    output logic [DIN_W-1:0]   din_data_o,
    input  logic               dout_valid_i,
    output logic               dout_ready_o,
    input  logic [DOUT_W-1:0]  dout_data_i,
    output logic               instr_valid_o,
    output logic [IADDR_W-1:0] instr_addr_o,
    output logic [DIN_W-1:0]   instr_data_o,
    output logic               err_o
);

    localparam int DIN_B  = DIN_W / 8;
    localparam int DOUT_B = DOUT_W / 8;
    localparam int RXC_W  = $clog2(DIN_B + 1);
    localparam int TXC_W  = $clog2(DOUT_B + 1);

    rx_state_e          rxState_q, rxState_d;
    cmd_e               cmd_q, cmd_d;
    cmd_e               hdrCmd;
    logic [RXC_W-1:0]   rxCnt_q, rxCnt_d;
    logic [DIN_W-1:0]   asm_q, asm_d, asmShift;
    logic [IADDR_W-1:0] addrHold_q, addrHold_d;
    logic [IADDR_W-1:0] instrAddr_q, instrAddr_d;
    logic [DIN_W-1:0]   instrData_q, instrData_d;
    logic               instrValid_q, instrValid_d;
    logic [2:0]         mode_q, mode_d;
    logic [BASE_W-1:0]  base_q, base_d;
    logic [31:0]        len_q, len_d;
    logic               err_q, err_d;
    logic               statPend_q, statPend_d;
    logic [7:0]         stat_q, stat_d;

    logic               rxFire;
    logic               txIdle, statLoad, txLoad;
    logic [DOUT_W-1:0]  txData;
    logic [TXC_W-1:0]   txLast;

    assign in_ready_o = ((rxState_q == RX_HDR) || (rxState_q == RX_PAY)) && !statPend_q;
    assign rxFire     = in_valid_i && in_ready_o;
    assign hdrCmd     = cmd_e'(in_data_i[7:5]);
    assign asmShift   = {in_data_i, asm_q[DIN_W-1:8]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxState_q    <= RX_HDR;
            cmd_q        <= CMD_NOP;
            rxCnt_q      <= '0;
            asm_q        <= '0;
            addrHold_q   <= '0;
            instrAddr_q  <= '0;
            instrData_q  <= '0;
            instrValid_q <= 1'b0;
            mode_q       <= '0;
            base_q       <= '0;
            len_q        <= '0;
            err_q        <= 1'b0;
            statPend_q   <= 1'b0;
            stat_q       <= '0;
        end else begin
            rxState_q    <= rxState_d;
            cmd_q        <= cmd_d;
            rxCnt_q      <= rxCnt_d;
            asm_q        <= asm_d;
            addrHold_q   <= addrHold_d;
            instrAddr_q  <= instrAddr_d;
            instrData_q  <= instrData_d;
            instrValid_q <= instrValid_d;
            mode_q       <= mode_d;
            base_q       <= base_d;
            len_q        <= len_d;
            err_q        <= err_d;
            statPend_q   <= statPend_d;
            stat_q       <= stat_d;
        end
    end

    // Short fields land in the top of the little-endian assembly register, so they are sliced from the MSB end.
    always_comb begin
        rxState_d    = rxState_q;
        cmd_d        = cmd_q;
        rxCnt_d      = rxCnt_q;
        asm_d        = asm_q;
        addrHold_d   = addrHold_q;
        instrAddr_d  = instrAddr_q;
        instrData_d  = instrData_q;
        instrValid_d = 1'b0;
        mode_d       = mode_q;
        base_d       = base_q;
        len_d        = len_q;
        err_d        = err_q;
        stat_d       = stat_q;
        statPend_d   = statPend_q;

        if (statLoad) begin
            statPend_d = 1'b0;
        end

        case (rxState_q)
            RX_HDR: begin
                if (rxFire) begin
                    cmd_d = hdrCmd;
                    case (hdrCmd)
                        CMD_NOP: ;
                        CMD_RD_STATUS: begin
                            stat_d     = {5'b0, err_q, done_i, busy_i};
                            statPend_d = 1'b1;
                            err_d      = 1'b0;
                        end
                        CMD_ILLEGAL: err_d = 1'b1;
                        default: begin
                            rxCnt_d   = RXC_W'(payloadBytes(hdrCmd, DIN_B) - 1);
                            rxState_d = RX_PAY;
                        end
                    endcase
                end
            end
            RX_PAY: begin
                if (rxFire) begin
                    asm_d = asmShift;
                    if ((cmd_q == CMD_WR_INSTR) && (rxCnt_q == RXC_W'(DIN_B))) begin
                        addrHold_d = IADDR_W'(in_data_i);
                    end
                    if (rxCnt_q == '0) begin
                        rxState_d = RX_HDR;
                        case (cmd_q)
                            CMD_SET_MODE: mode_d = in_data_i[2:0];
                            CMD_SET_BASE: base_d = asmShift[DIN_W-16 +: BASE_W];
                            CMD_SET_LEN:  len_d  = asmShift[DIN_W-32 +: 32];
                            CMD_WR_INSTR: begin
                                instrValid_d = 1'b1;
                                instrAddr_d  = addrHold_q;
                                instrData_d  = asmShift;
                            end
                            CMD_WR_DATA:  rxState_d = RX_ISSUE;
                            default: ;
                        endcase
                    end else begin
                        rxCnt_d = rxCnt_q - RXC_W'(1);
                    end
                end
            end
            RX_ISSUE: begin
                if (din_ready_i) begin
                    rxState_d = RX_HDR;
                end
            end
            default: rxState_d = RX_HDR;
        endcase
    end

    // A pending status byte wins the serializer over a dout word offered in the same cycle.
    assign statLoad     = txIdle && statPend_q;
    assign dout_ready_o = txIdle && !statPend_q;
    assign txLoad       = statLoad || (dout_ready_o && dout_valid_i);
    assign txData       = statLoad ? DOUT_W'(stat_q) : dout_data_i;
    assign txLast       = statLoad ? TXC_W'(STAT_BYTES - 1) : TXC_W'(DOUT_B - 1);

    tpu_tx_serializer #(
        .DATA_W (DOUT_W),
        .CNT_W  (TXC_W)
    ) u_tx (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (txLoad),
        .data_i      (txData),
        .last_i      (txLast),
        .idle_o      (txIdle),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o)
    );

    assign din_valid_o   = (rxState_q == RX_ISSUE);
    assign din_data_o    = asm_q;
    assign instr_valid_o = instrValid_q;
    assign instr_addr_o  = instrAddr_q;
    assign instr_data_o  = instrData_q;
    assign tpu_mode_o    = mode_q;
    assign base_addr_o   = base_q;
    assign dma_len_o     = len_q;
    assign err_o         = err_q;

endmodule
